calculator: RTL and testbench

CALCULATOR -- requirements
Module: calculator

---
 rtl/calculator.sv | 65 ++++++
 tb/tb_calculator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/calculator.sv
// Single-cycle registered ALU: add, subtract, AND and OR on unsigned operands.
// The result is WIDTH+1 bits wide, and zero/neg flags are registered alongside it.
module calculator #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Op,
    input  logic             in_valid,
    output logic [WIDTH:0]   Result,
    output logic             out_valid,
    output logic             zero,
    output logic             neg
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    op_t            op_sel;
    logic [WIDTH:0] next_result;
    logic           next_neg;

    always_comb begin
        op_sel      = op_t'(Op);
        next_result = '0;
        next_neg    = 1'b0;
        case (op_sel)
            OP_ADD: next_result = {1'b0, A} + {1'b0, B};
            OP_SUB: begin
                // WIDTH+1-bit wraparound makes the top bit the borrow, i.e. A < B
                next_result = {1'b0, A} - {1'b0, B};
                next_neg    = (A < B);
            end
            OP_AND: next_result = {1'b0, A & B};
            OP_OR:  next_result = {1'b0, A | B};
            default: begin
                next_result = '0;
                next_neg    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result    <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b1;
            neg       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Result <= next_result;
                zero   <= (next_result == '0);
                neg    <= next_neg;
            end
        end
    end

endmodule

// File: tb/tb_calculator.sv
// Directed bench for calculator: a table of back-to-back operations, followed by
// hand-written hold and reset sequences.
module tb_calculator;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       Op;
    logic             in_valid;
    logic [WIDTH:0]   Result;
    logic             out_valid;
    logic             zero;
    logic             neg;

    int unsigned n_checks;
    int unsigned n_fails;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [4:0] res;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vecs[13];

    calculator #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Op       (Op),
        .in_valid (in_valid),
        .Result   (Result),
        .out_valid(out_valid),
        .zero     (zero),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] r, input logic ov,
                           input logic z, input logic n);
        chk({tag, " Result"}, 32'(Result), 32'(r));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " zero"}, 32'(zero), 32'(z));
        chk({tag, " neg"}, 32'(neg), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;

        vecs[0]  = '{4'd5,  4'd3,  2'b00, 5'd8,  1'b0, 1'b0};
        vecs[1]  = '{4'd10, 4'd4,  2'b01, 5'd6,  1'b0, 1'b0};
        vecs[2]  = '{4'd3,  4'd5,  2'b01, 5'd30, 1'b0, 1'b1};
        vecs[3]  = '{4'hC,  4'hA,  2'b10, 5'd8,  1'b0, 1'b0};
        vecs[4]  = '{4'hC,  4'hA,  2'b11, 5'd14, 1'b0, 1'b0};
        vecs[5]  = '{4'd15, 4'd15, 2'b00, 5'd30, 1'b0, 1'b0};
        vecs[6]  = '{4'd7,  4'd7,  2'b01, 5'd0,  1'b1, 1'b0};
        vecs[7]  = '{4'd0,  4'd15, 2'b10, 5'd0,  1'b1, 1'b0};
        vecs[8]  = '{4'd0,  4'd15, 2'b01, 5'd17, 1'b0, 1'b1};
        vecs[9]  = '{4'd15, 4'd0,  2'b01, 5'd15, 1'b0, 1'b0};
        vecs[10] = '{4'd0,  4'd0,  2'b00, 5'd0,  1'b1, 1'b0};
        vecs[11] = '{4'd15, 4'd0,  2'b11, 5'd15, 1'b0, 1'b0};
        vecs[12] = '{4'd9,  4'd6,  2'b10, 5'd0,  1'b1, 1'b0};

        rst = 1'b1;
        A = '0;
        B = '0;
        Op = 2'b00;
        in_valid = 1'b0;
        #1;
        chk_all("reset_state", 5'd0, 1'b0, 1'b1, 1'b0);

        // an operation offered during reset must be discarded
        @(negedge clk);
        A = 4'd5; B = 4'd3; Op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        chk_all("reset_discard", 5'd0, 1'b0, 1'b1, 1'b0);

        // first valid edge after reset release is accepted
        @(negedge clk);
        rst = 1'b0;
        A = 4'd3; B = 4'd5; Op = 2'b01;
        @(posedge clk); #1;
        chk_all("post_reset_first", 5'd30, 1'b1, 1'b0, 1'b1);

        // back-to-back table; out_valid stays high on each edge
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            A = vecs[i].a; B = vecs[i].b; Op = vecs[i].op; in_valid = 1'b1;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].res, 1'b1, vecs[i].z, vecs[i].n);
        end

        // hold: accept 5+3, then idle for three cycles with inputs moving
        @(negedge clk);
        A = 4'd5; B = 4'd3; Op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        chk_all("hold_accept", 5'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A = 4'(i + 1); B = 4'(14 - i); Op = 2'(i + 1);
            @(posedge clk); #1;
            chk_all($sformatf("hold%0d", i), 5'd8, 1'b0, 1'b0, 1'b0);
        end

        // asynchronous reset between edges while Result=8
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_reset", 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // reset arriving after an operation is presented but before its edge
        @(negedge clk);
        A = 4'd15; B = 4'd15; Op = 2'b00; in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all("midop_reset_now", 5'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_all("midop_reset_edge", 5'd0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        A = 4'd12; B = 4'd3; Op = 2'b11; in_valid = 1'b1;
        @(posedge clk); #1;
        chk_all("recover_or", 5'd15, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk_all("single_pulse", 5'd15, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
